mem_responder: RTL and testbench

//  Memory-side responder for the multicycle processor's memory port.

---
 rtl/mem_if.sv | 27 ++
 rtl/mem_responder.sv | 125 ++++++++++++
 tb/tb_mem_responder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_if.sv
// Memory port between the processor controller/datapath and the memory responder.
// The controller drives the request strobes, address and write data.
// The responder returns read data, the completion pulses, busy and err.
interface mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_rd;
  logic              mem_wr_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              wack;
  logic              busy;
  logic              err;

  modport master (
    output mem_rd, mem_wr_n, addr, wdata,
    input  rdata, rvalid, wack, busy, err
  );

  modport slave (
    input  mem_rd, mem_wr_n, addr, wdata,
    output rdata, rvalid, wack, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle processor's memory port.
// A request is accepted in IDLE, waits WAIT_CYC cycles in WAIT, and performs the
// access on the edge that leaves WAIT. It then spends one cycle in RESP, where it
// raises rvalid or wack. Every output is driven straight from a register.
module mem_responder #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 2
) (
  input  logic   clk,
  input  logic   proc_rst,
  mem_if.slave   bus
);

  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [3:0]        WAIT_LD = 4'(WAIT_CYC);
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              wack_q;
  logic              busy_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_req;
  logic              wr_req;
  logic              accept;
  logic              access;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  assign rd_req   = bus.mem_rd;
  assign wr_req   = ~bus.mem_wr_n;
  // A collision (both strobes active) is never accepted.
  assign accept   = (state == IDLE) && (rd_req ^ wr_req);
  // The access edge is the one that takes WAIT to RESP.
  assign access   = (state == WAIT) && (cnt == 4'd0);
  // Check the full address first, so high addresses cannot alias onto low words.
  assign in_range = ({1'b0, addr_q} < DEPTH_W);
  assign idx      = addr_q[IDX_W-1:0];

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.wack   = wack_q;
  assign bus.busy   = busy_q;
  assign bus.err    = err_q;

  // Capture the request fields when a request is accepted. Later changes on the bus are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
    end
  end

  // Storage write. Reset forces state to IDLE, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (access && op_wr && in_range) begin
      mem[idx] <= wdata_q;
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      op_wr    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wack_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      wack_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req && wr_req) begin
            err_q <= 1'b1;
          end else if (accept) begin
            op_wr  <= wr_req;
            cnt    <= WAIT_LD;
            busy_q <= 1'b1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= RESP;
            err_q <= ~in_range;
            if (op_wr) begin
              wack_q <= 1'b1;
            end else begin
              rvalid_q <= 1'b1;
              rdata_q  <= in_range ? mem[idx] : '0;
            end
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder. Three instances run side by side: WAIT_CYC=2
// is the main target, and WAIT_CYC=0 and WAIT_CYC=15 are used for the latency
// extremes. Inputs change on the falling edge, and outputs are sampled there too.
module tb_mem_responder;

  logic clk;
  logic proc_rst;
  int   tests;
  int   fails;

  mem_if #(.DATA_W(16), .ADDR_W(16)) b2  ();
  mem_if #(.DATA_W(16), .ADDR_W(16)) b0  ();
  mem_if #(.DATA_W(16), .ADDR_W(16)) b15 ();

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYC(2))
    u_dut (.clk(clk), .proc_rst(proc_rst), .bus(b2));
  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYC(0))
    u_w0 (.clk(clk), .proc_rst(proc_rst), .bus(b0));
  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYC(15))
    u_w15 (.clk(clk), .proc_rst(proc_rst), .bus(b15));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs == exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one single-cycle request on the WAIT_CYC=2 instance. The call starts at a
  // falling edge, and the next rising edge is E0.
  task automatic op2(input string tag, input logic wr, input logic [15:0] a,
                     input logic [15:0] d, input logic [15:0] exp_rd, input logic exp_err);
    b2.mem_rd   = ~wr;
    b2.mem_wr_n = ~wr;
    b2.addr     = a;
    b2.wdata    = d;
    @(negedge clk);                       // after E0
    b2.mem_rd   = 1'b0;
    b2.mem_wr_n = 1'b1;
    b2.addr     = ~a;
    b2.wdata    = ~d;
    chk1({tag, " busy@E0"}, b2.busy, 1'b1);
    repeat (2) @(negedge clk);            // after E2
    chk1({tag, " busy@E2"}, b2.busy, 1'b1);
    chk1({tag, " early pulse@E2"}, b2.rvalid | b2.wack, 1'b0);
    @(negedge clk);                       // after E3: response cycle
    chk1({tag, " rvalid@E3"}, b2.rvalid, ~wr);
    chk1({tag, " wack@E3"}, b2.wack, wr);
    chk1({tag, " err@E3"}, b2.err, exp_err);
    chk1({tag, " busy@E3"}, b2.busy, 1'b1);
    if (!wr) chk16({tag, " rdata@E3"}, b2.rdata, exp_rd);
    @(negedge clk);                       // after E4: back in IDLE
    chk1({tag, " busy@E4"}, b2.busy, 1'b0);
    chk1({tag, " pulse@E4"}, b2.rvalid | b2.wack, 1'b0);
    chk1({tag, " err@E4"}, b2.err, 1'b0);
  endtask

  // Issues the same request to the WAIT_CYC=0 and WAIT_CYC=15 instances. It records
  // the edge index k (after E0) at which each completion pulse first appears.
  task automatic op_ext(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        output int lat0, output int lat15,
                        output logic [15:0] rd0, output logic [15:0] rd15);
    lat0 = 0; lat15 = 0; rd0 = '0; rd15 = '0;
    b0.mem_rd = ~wr;  b0.mem_wr_n = ~wr;  b0.addr = a;  b0.wdata = d;
    b15.mem_rd = ~wr; b15.mem_wr_n = ~wr; b15.addr = a; b15.wdata = d;
    @(negedge clk);                       // after E0
    b0.mem_rd = 1'b0;  b0.mem_wr_n = 1'b1;
    b15.mem_rd = 1'b0; b15.mem_wr_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (lat0 == 0 && (b0.rvalid | b0.wack)) begin
        lat0 = k; rd0 = b0.rdata;
      end
      if (lat15 == 0 && (b15.rvalid | b15.wack)) begin
        lat15 = k; rd15 = b15.rdata;
      end
    end
  endtask

  initial begin
    int          lat0;
    int          lat15;
    logic [15:0] rd0;
    logic [15:0] rd15;

    tests = 0;
    fails = 0;
    proc_rst = 1'b0;
    b2.mem_rd = 1'b0;  b2.mem_wr_n = 1'b1;  b2.addr = '0;  b2.wdata = '0;
    b0.mem_rd = 1'b0;  b0.mem_wr_n = 1'b1;  b0.addr = '0;  b0.wdata = '0;
    b15.mem_rd = 1'b0; b15.mem_wr_n = 1'b1; b15.addr = '0; b15.wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst busy", b2.busy, 1'b0);
    chk1("rst rvalid", b2.rvalid, 1'b0);
    chk1("rst wack", b2.wack, 1'b0);
    chk1("rst err", b2.err, 1'b0);
    chk16("rst rdata", b2.rdata, 16'h0000);
    proc_rst = 1'b1;
    @(negedge clk);

    // T1: write, then read back
    op2("t1 wr5", 1'b1, 16'd5, 16'hA5A5, 16'h0000, 1'b0);
    op2("t1 rd5", 1'b0, 16'd5, 16'h0000, 16'hA5A5, 1'b0);

    // T2: request held across two reads; address change during busy ignored
    op2("t2 wr1", 1'b1, 16'd1, 16'h0011, 16'h0000, 1'b0);
    op2("t2 wr2", 1'b1, 16'd2, 16'h0022, 16'h0000, 1'b0);
    b2.mem_rd = 1'b1;
    b2.addr   = 16'd1;
    @(negedge clk);                       // after E0
    b2.addr = 16'd2;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk1($sformatf("t2 rvalid k=%0d", k), b2.rvalid, (k == 3 || k == 8));
      if (k == 3) chk16("t2 rdata first", b2.rdata, 16'h0011);
      if (k == 8) chk16("t2 rdata second", b2.rdata, 16'h0022);
    end
    b2.mem_rd = 1'b0;
    repeat (2) @(negedge clk);
    chk1("t2 idle busy", b2.busy, 1'b0);

    // T3: collision
    op2("t3 wr9", 1'b1, 16'd9, 16'h5A5A, 16'h0000, 1'b0);
    b2.mem_rd   = 1'b1;
    b2.mem_wr_n = 1'b0;
    b2.addr     = 16'd9;
    b2.wdata    = 16'hFFFF;
    @(negedge clk);
    b2.mem_rd   = 1'b0;
    b2.mem_wr_n = 1'b1;
    chk1("t3 err", b2.err, 1'b1);
    chk1("t3 busy", b2.busy, 1'b0);
    chk16("t3 rdata kept", b2.rdata, 16'h0022);
    @(negedge clk);
    chk1("t3 err cleared", b2.err, 1'b0);
    chk1("t3 still idle", b2.busy, 1'b0);
    op2("t3 rd9", 1'b0, 16'd9, 16'h0000, 16'h5A5A, 1'b0);

    // T4: out-of-range write and read
    op2("t4 wr0", 1'b1, 16'd0, 16'h0BEE, 16'h0000, 1'b0);
    op2("t4 wr100", 1'b1, 16'h0100, 16'hDEAD, 16'h0000, 1'b1);
    op2("t4 rd0", 1'b0, 16'd0, 16'h0000, 16'h0BEE, 1'b0);
    op2("t4 rdFFFF", 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1);

    // T5: reset in the middle of a write
    op2("t5 wr7", 1'b1, 16'd7, 16'h1234, 16'h0000, 1'b0);
    b2.mem_wr_n = 1'b0;
    b2.addr     = 16'd7;
    b2.wdata    = 16'h9999;
    @(negedge clk);                       // after E0
    b2.mem_wr_n = 1'b1;
    @(negedge clk);                       // after E1, still waiting
    chk1("t5 busy before rst", b2.busy, 1'b1);
    proc_rst = 1'b0;
    #1;
    chk1("t5 busy in rst", b2.busy, 1'b0);
    chk1("t5 wack in rst", b2.wack, 1'b0);
    chk1("t5 rvalid in rst", b2.rvalid, 1'b0);
    chk1("t5 err in rst", b2.err, 1'b0);
    chk16("t5 rdata in rst", b2.rdata, 16'h0000);
    repeat (2) @(negedge clk);
    proc_rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk1($sformatf("t5 no pulse k=%0d", k), b2.rvalid | b2.wack | b2.busy, 1'b0);
    end
    op2("t5 rd7", 1'b0, 16'd7, 16'h0000, 16'h1234, 1'b0);

    // T6: latency at WAIT_CYC=0 and WAIT_CYC=15
    op_ext(1'b1, 16'd3, 16'h0333, lat0, lat15, rd0, rd15);
    chk_int("t6 w0 wack latency", lat0, 1);
    chk_int("t6 w15 wack latency", lat15, 16);
    op_ext(1'b0, 16'd3, 16'h0000, lat0, lat15, rd0, rd15);
    chk_int("t6 w0 rvalid latency", lat0, 1);
    chk_int("t6 w15 rvalid latency", lat15, 16);
    chk16("t6 w0 rdata", rd0, 16'h0333);
    chk16("t6 w15 rdata", rd15, 16'h0333);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
